// File: rtl/cpu_core_p_if.sv
// External memory bus for cpu_core_p: registered req/we/addr/wdata from the
// core, rdata/ack back from memory. Ack completes the pending access.
interface cpu_core_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multicycle CPU core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with a req/ack memory port, Z/N flags and conditional branches.
// Optional build macro CPU_R0_ZERO_EN: R0 is hardwired to zero (writes dropped,
// flags still follow the computed result).
module cpu_core_p #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              reset,
  cpu_core_p_if.master      mem,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);
  localparam int SHW = $clog2(DATA_W);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_SRI  = 5'd13;
  localparam logic [4:0] OP_EQ   = 5'd16;
  localparam logic [4:0] OP_BR   = 5'd17;
  localparam logic [4:0] OP_STW  = 5'd18;
  localparam logic [4:0] OP_LDW  = 5'd19;
  localparam logic [4:0] OP_BRZ  = 5'd20;
  localparam logic [4:0] OP_BRN  = 5'd21;
  localparam logic [4:0] OP_HALT = 5'd31;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, mdr_q, mdr_d;
  logic              z_q, z_d, n_q, n_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0] rf_view [8];
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  // Instruction fields of the latched IR
  logic [4:0] op;
  logic [2:0] rd, ra, rb;
  logic       is_imm;
  logic [4:0] alu_sel;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] pc_inc, imm8;

  assign op      = ir_q[15:11];
  assign rd      = ir_q[10:8];
  assign ra      = ir_q[7:5];
  assign rb      = ir_q[4:2];
  assign is_imm  = (op >= OP_ADDI) && (op <= OP_SRI);
  assign alu_sel = is_imm ? (op - 5'd7) : op;
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign imm8    = ADDR_W'(ir_q[7:0]);

  // Register file: eight flops, one generate slice each
  for (genvar gi = 0; gi < 8; gi++) begin : g_rf
    logic [DATA_W-1:0] r_q, r_d;

    // Next value: take the write-back data when this register is addressed
    always_comb begin
      r_d = r_q;
      if (wr_en && (rd == 3'(gi))) r_d = wr_data;
`ifdef CPU_R0_ZERO_EN
      if (gi == 0) r_d = '0;
`endif
    end

    // Register storage, cleared on reset
    always_ff @(posedge CLK) begin
      if (reset) r_q <= '0;
      else       r_q <= r_d;
    end

    assign rf_view[gi] = r_q;
  end

  // ALU on the operands latched in DECODE; shifts use the low SHW bits of B
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      5'd0:  alu_res = a_q + b_q;
      5'd1:  alu_res = a_q - b_q;
      5'd2:  alu_res = a_q | b_q;
      5'd3:  alu_res = a_q & b_q;
      5'd4:  alu_res = a_q ^ b_q;
      5'd5:  alu_res = a_q << b_q[SHW-1:0];
      5'd6:  alu_res = a_q >> b_q[SHW-1:0];
      5'd14: alu_res = DATA_W'($signed(a_q) > $signed(b_q));
      5'd15: alu_res = DATA_W'($signed(a_q) < $signed(b_q));
      5'd16: alu_res = DATA_W'(a_q == b_q);
      default: alu_res = '0;
    endcase
  end

  // Sequencing FSM plus the registered memory handshake
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    mdr_d   = mdr_q;
    z_d     = z_q;
    n_d     = n_q;
    wr_en   = 1'b0;
    wr_data = alu_res;

    case (state_q)
      ST_FETCH: begin
        if (req_q && mem.ack) begin
          ir_d    = mem.rdata[15:0];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rf_view[ra];
        b_d     = is_imm ? DATA_W'(ir_q[4:0]) : rf_view[rb];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (op <= OP_EQ) begin
          wr_en = 1'b1;
          z_d   = (alu_res == '0);
          n_d   = alu_res[DATA_W-1];
        end else begin
          case (op)
            OP_BR:  pc_d = imm8;
            OP_BRZ: pc_d = z_q ? imm8 : pc_inc;
            OP_BRN: pc_d = n_q ? imm8 : pc_inc;
            OP_STW, OP_LDW: begin
              pc_d    = pc_q;
              state_d = ST_MEM;
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        if (req_q && mem.ack) begin
          if (op == OP_LDW) begin
            mdr_d   = mem.rdata;
            state_d = ST_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        wr_en   = 1'b1;
        wr_data = mdr_q;
        z_d     = (mdr_q == '0);
        n_d     = mdr_q[DATA_W-1];
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    // Request is held through the ack cycle and always drops for one cycle
    // afterwards; address/data are captured only when the request rises.
    req_d   = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && !(req_q && mem.ack);
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (req_d && !req_q) begin
      if (state_d == ST_MEM) begin
        addr_d  = ADDR_W'(a_q);
        we_d    = (op == OP_STW);
        wdata_d = b_q;
      end else begin
        addr_d  = pc_d;
        we_d    = 1'b0;
      end
    end else if (!req_d) begin
      we_d = 1'b0;
    end
  end

  // State and bus registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mdr_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mdr_q   <= mdr_d;
      z_q     <= z_d;
      n_q     <= n_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign halted    = (state_q == ST_HALT);
  assign pc_out    = pc_q;
endmodule

// File: doc/cpu_core_p.md
Name: cpu_core_p

Overview:
- Parametrised next-generation multicycle CPU core for the FPGA CPU project.
- Generalises the 16-bit, fixed-memory CPU with configurable data/address width, a req/ack external memory handshake, Z/N flags with conditional branches, and a HALT state.
- Sits between the system bus (external memory) and the debug/top-level wrapper.

Parameters:
- DATA_W, 16, register/ALU/memory data width; must be >= 16.
- ADDR_W, 16, memory address width; PC width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  memory request; held until ack.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  ADDR_W  access address; valid while mem_req.
- mem_wdata  output  DATA_W  store data; valid while mem_req && mem_we.
- mem_rdata  input  DATA_W  read data; sampled in the ack cycle.
- mem_ack  input  1  access complete; ignored when mem_req = 0.
- halted  output  1  high while in HALT.
- pc_out  output  ADDR_W  current PC (debug).

Behaviour:
- Reset: PC = RESET_PC; R0..R7 = 0; Z = N = 0; IR = 0; state FETCH; mem_req = mem_we = 0; halted = 0.
- Reset mid-access drops mem_req the next cycle. Memory must discard the pending access.
- Instruction format, 16 bits, taken from mem_rdata[15:0]:
  - op = [15:11], rd = [10:8], ra = [7:5], rb = [4:2].
  - imm5 = [4:0], zero-extended to DATA_W.
  - imm8 = [7:0], zero-extended to ADDR_W.
- Opcodes (A = R[ra], B = R[rb] or imm5 for immediate forms):
  - 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SL, 6 SR.
  - 7-13: the same operations with imm5.
  - 14 GT, 15 LT, 16 EQ: signed compare; rd = 1 or 0.
  - 17 BR: PC = imm8. 18 STW: mem[A] = R[rb]. 19 LDW: R[rd] = mem[A].
  - 20 BRZ: PC = imm8 if Z, else PC+1. 21 BRN: PC = imm8 if N, else PC+1.
  - 31 HALT. 22-30 are NOPs.
- Arithmetic wraps modulo 2^DATA_W.
- Shift amount = low clog2(DATA_W) bits of B. SR is logical.
- Z/N are updated from the written result by opcodes 0-16 and LDW only.
- PC increments modulo 2^ADDR_W. Memory addresses are the low ADDR_W bits of A.
- FSM states:
  - FETCH: mem_req = 1, addr = PC, we = 0. On ack: IR = rdata[15:0], go DECODE.
  - DECODE: 1 cycle; latch A and B.
  - EXEC: 1 cycle. ALU/branch/NOP ops write rd and flags, update PC, go FETCH. LDW/STW go MEM. HALT goes HALT.
  - MEM: mem_req = 1, addr = A, we = (STW), wdata = R[rb]. On ack: STW does PC+1 and goes FETCH; LDW latches MDR and goes WB.
  - WB: R[rd] = MDR, flags updated, PC+1, go FETCH.
  - HALT: terminal. halted = 1, mem_req = 0. Exit only by reset.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable from req rise through the ack cycle.
  - mem_req falls in the cycle after ack.
  - Ack is legal no earlier than the cycle after req rises. Same-cycle ack is not supported.
- Timing with 1-wait memory (ack one cycle after req):
  - ALU/branch: 4 cycles. STW: 6 cycles. LDW: 7 cycles.
- A read and write of the same register in one instruction (e.g. ADD R1,R1,R1) uses the old value.

Optional Feature:
- CPU_R0_ZERO_EN defined:
  - R0 always reads 0; writes to R0 are discarded.
  - Flags still update from the computed result.
- CPU_R0_ZERO_EN undefined: R0 is a normal register.

Test Plan:
- Reset then release with RESET_PC = 0x0010 -> first mem_req has addr 0x0010, we = 0; halted = 0; all registers read 0.
- ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2 with ack 1 cycle after req -> R3 = 2, Z = 0, N = 0; each instruction retires in 4 cycles.
- SUB R4,R2,R1 (3-5), DATA_W = 16 -> R4 = 0xFFFE, N = 1. Then BRN 0x40 -> next fetch addr 0x0040. BRZ 0x40 with Z = 0 -> fetch PC+1.
- STW R1 to [R5 = 0x80] then LDW R6,[R5], with ack delayed 3 cycles -> write addr 0x80 data 5; mem_req/addr/wdata stable until ack; R6 = 5.
- Assert reset during a LDW MEM wait -> mem_req low next cycle; PC = RESET_PC; rd unchanged from its reset value 0.
- HALT -> halted = 1; no further mem_req for 20 cycles. Repeat with DATA_W = 32: ADDI/SLI R1 by 20 -> 0x00500000 (from imm 5).
